// File: rtl/sample_buf_pkg.sv
// Shared constants and types for the multi-channel sample buffer.
// The capture (writer) side and the frame reader both import this package.
package sample_buf_pkg;

  localparam int NUM_CHANNELS = 14;
  localparam int NUM_SAMPLES  = 10;
  localparam int SAMPLE_W     = 8;

  localparam logic [SAMPLE_W-1:0] SYNC_BYTE = 8'hA5;

  // Address widths never collapse to zero, even for single-entry geometries.
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  localparam int FRAME_LEN = NUM_CHANNELS * NUM_SAMPLES + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_RD,
    ST_CAP,
    ST_SEND,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/sample_addr_counter.sv
// Two-level read address counter: sample index is the fast digit, channel the slow one.
// last flags the final (channel, sample) pair of a frame.
module sample_addr_counter
  import sample_buf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [CH_W-1:0]  ch,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);

  logic [CH_W-1:0]  ch_reg,  ch_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  always_comb begin
    ch_next  = ch_reg;
    idx_next = idx_reg;
    if (clear) begin
      ch_next  = '0;
      idx_next = '0;
    end else if (advance) begin
      if (idx_reg == IDX_LAST) begin
        idx_next = '0;
        ch_next  = (ch_reg == CH_LAST) ? '0 : ch_reg + CH_W'(1);
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_reg  <= '0;
      idx_reg <= '0;
    end else begin
      ch_reg  <= ch_next;
      idx_reg <= idx_next;
    end
  end

  assign ch   = ch_reg;
  assign idx  = idx_reg;
  assign last = (ch_reg == CH_LAST) && (idx_reg == IDX_LAST);

endmodule

// File: rtl/sample_frame_reader.sv
// Reads every channel history buffer and streams one framed dump per start:
// sync, sequence, samples (channel-major, oldest first), then an 8-bit additive checksum.
module sample_frame_reader
  import sample_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [CH_W-1:0]     rd_ch,
  output logic [IDX_W-1:0]    rd_idx,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic [SAMPLE_W-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  state_t state_reg, state_next;

  logic [SAMPLE_W-1:0] tx_data_reg, tx_data_next;
  logic                tx_valid_reg, tx_valid_next;
  logic [SAMPLE_W-1:0] acc_reg, acc_next;
  logic [SAMPLE_W-1:0] seq_reg, seq_next;
  logic                done_reg, done_next;

  logic cnt_clear;
  logic cnt_advance;
  logic cnt_last;
  logic handshake;

  assign handshake = tx_valid_reg && tx_ready;

  sample_addr_counter u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .ch      (rd_ch),
    .idx     (rd_idx),
    .last    (cnt_last)
  );

  always_comb begin
    state_next    = state_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    acc_next      = acc_reg;
    seq_next      = seq_reg;
    done_next     = 1'b0;
    cnt_clear     = 1'b0;
    cnt_advance   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_SYNC;
          tx_data_next  = SYNC_BYTE;
          tx_valid_next = 1'b1;
          cnt_clear     = 1'b1;
        end
      end

      ST_SYNC: begin
        if (handshake) begin
          state_next   = ST_SEQ;
          tx_data_next = seq_reg;
        end
      end

      // The sequence byte seeds the checksum; the sync byte does not.
      ST_SEQ: begin
        if (handshake) begin
          state_next    = ST_RD;
          tx_valid_next = 1'b0;
          acc_next      = seq_reg;
        end
      end

      ST_RD: begin
        state_next = ST_CAP;
      end

      ST_CAP: begin
        state_next    = ST_SEND;
        tx_data_next  = rd_data;
        tx_valid_next = 1'b1;
      end

      // On the last sample the running sum goes straight out as the checksum byte.
      ST_SEND: begin
        if (handshake) begin
          acc_next    = acc_reg + tx_data_reg;
          cnt_advance = 1'b1;
          if (cnt_last) begin
            state_next   = ST_CSUM;
            tx_data_next = acc_reg + tx_data_reg;
          end else begin
            state_next    = ST_RD;
            tx_valid_next = 1'b0;
          end
        end
      end

      ST_CSUM: begin
        if (handshake) begin
          state_next    = ST_IDLE;
          tx_valid_next = 1'b0;
          done_next     = 1'b1;
          seq_next      = seq_reg + SAMPLE_W'(1);
        end
      end

      default: begin
        state_next    = ST_IDLE;
        tx_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      acc_reg      <= '0;
      seq_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      acc_reg      <= acc_next;
      seq_reg      <= seq_next;
      done_reg     <= done_next;
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign rd_en    = (state_reg == ST_RD);
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_sample_frame_reader.sv
// Directed bench for sample_frame_reader: buffer model returns ch*16+idx one cycle after rd_en.
module tb_sample_frame_reader;
  import sample_buf_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [CH_W-1:0]     rd_ch;
  logic [IDX_W-1:0]    rd_idx;
  logic [SAMPLE_W-1:0] rd_data = '0;
  logic [SAMPLE_W-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  sample_frame_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= 8'(int'(rd_ch) * 16 + int'(rd_idx));
  end

  typedef struct {
    logic [7:0]       data;
    logic             rd_en_d2;
    logic [CH_W-1:0]  ch_d2;
    logic [IDX_W-1:0] idx_d2;
    logic             busy_prev;
  } rise_t;

  logic [7:0] stream_q[$];
  rise_t      rise_q[$];
  int         done_cnt = 0;

  logic             rd_en_d1 = 1'b0, rd_en_d2 = 1'b0;
  logic [CH_W-1:0]  ch_d1 = '0, ch_d2 = '0;
  logic [IDX_W-1:0] idx_d1 = '0, idx_d2 = '0;
  logic             valid_prev = 1'b0, busy_prev = 1'b0;

  // Monitor samples on the falling edge: accepted bytes, done pulses, tx_valid rises.
  always @(negedge clk) begin : mon
    rise_t r;
    if (tx_valid && tx_ready) stream_q.push_back(tx_data);
    if (done) done_cnt++;
    if (tx_valid && !valid_prev) begin
      r.data      = tx_data;
      r.rd_en_d2  = rd_en_d2;
      r.ch_d2     = ch_d2;
      r.idx_d2    = idx_d2;
      r.busy_prev = busy_prev;
      rise_q.push_back(r);
    end
    rd_en_d2   = rd_en_d1;
    rd_en_d1   = rd_en;
    ch_d2      = ch_d1;
    ch_d1      = rd_ch;
    idx_d2     = idx_d1;
    idx_d1     = rd_idx;
    valid_prev = tx_valid;
    busy_prev  = busy;
  end

  function automatic logic [7:0] model_sample(int ch, int idx);
    return 8'(ch * 16 + idx);
  endfunction

  function automatic logic [7:0] model_byte(logic [7:0] seq, int i);
    logic [7:0] s;
    if (i == 0) return 8'hA5;
    if (i == 1) return seq;
    if (i <= NUM_CHANNELS * NUM_SAMPLES + 1)
      return model_sample((i - 2) / NUM_SAMPLES, (i - 2) % NUM_SAMPLES);
    s = seq;
    for (int k = 0; k < NUM_CHANNELS * NUM_SAMPLES; k++)
      s = s + model_sample(k / NUM_SAMPLES, k % NUM_SAMPLES);
    return s;
  endfunction

  // Index of the first byte that differs from nframes consecutive frames starting at seq0, else -1.
  function automatic int first_bad(logic [7:0] seq0, int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        int p;
        p = f * FRAME_LEN + i;
        if (p >= stream_q.size()) return p;
        if (stream_q[p] !== model_byte(8'(int'(seq0) + f), i)) return p;
      end
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (stream_q.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (rd_ch !== '0 || rd_idx !== '0) begin failures++; $display("FAIL reset_addr: got ch=%0d idx=%0d expected 0/0", rd_ch, rd_idx); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start_busy: got %b expected 0", busy); end
    $display("test_reset: done");
  endtask

  task automatic test_basic_frame();
    bit to;
    int bad;
    stream_q.delete();
    done_cnt = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    wait_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL basic_done_timeout: got timeout expected done"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (stream_q.size() != FRAME_LEN) begin failures++; $display("FAIL basic_len: got %0d expected %0d", stream_q.size(), FRAME_LEN); end
    bad = first_bad(8'h00, 1);
    checks++; if (bad != -1) begin failures++; $display("FAIL basic_stream: first bad byte at %0d expected none", bad); end
    checks++; if (stream_q.size() < FRAME_LEN || stream_q[FRAME_LEN-1] !== 8'h56) begin
      failures++; $display("FAIL basic_csum: got %h expected 56", (stream_q.size() >= FRAME_LEN) ? stream_q[FRAME_LEN-1] : 8'hxx); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    $display("test_basic_frame: %0d bytes", stream_q.size());
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    do_reset();
    stream_q.delete();
    pulse_start();
    wait_bytes(3, 100, to);
    checks++; if (to) begin failures++; $display("FAIL bp_wait_bytes: got timeout expected 3 bytes"); end
    tx_ready = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
        failures++; $display("FAIL bp_hold: cycle %0d got valid=%b data=%h expected 1/01", c, tx_valid, tx_data); end
      checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en: cycle %0d got %b expected 0", c, rd_en); end
      @(posedge clk); #1;
    end
    checks++; if (stream_q.size() != 3) begin failures++; $display("FAIL bp_no_accept: got %0d bytes expected 3", stream_q.size()); end
    tx_ready = 1'b1;
    wait_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL bp_done_timeout: got timeout expected done"); end
    @(posedge clk); #1;
    checks++; if (stream_q.size() != FRAME_LEN) begin failures++; $display("FAIL bp_len: got %0d expected %0d", stream_q.size(), FRAME_LEN); end
    bad = first_bad(8'h00, 1);
    checks++; if (bad != -1) begin failures++; $display("FAIL bp_stream: first bad byte at %0d expected none", bad); end
    $display("test_backpressure: %0d bytes", stream_q.size());
  endtask

  task automatic test_ignore_start();
    bit to;
    int bad;
    do_reset();
    stream_q.delete();
    pulse_start();
    wait_bytes(20, 200, to);
    pulse_start();
    wait_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL ign_done_timeout: got timeout expected done"); end
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue: got busy=%b expected 0", busy); end
    checks++; if (stream_q.size() != FRAME_LEN) begin failures++; $display("FAIL ign_len: got %0d expected %0d", stream_q.size(), FRAME_LEN); end
    stream_q.delete();
    pulse_start();
    wait_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL ign_done2_timeout: got timeout expected done"); end
    @(posedge clk); #1;
    bad = first_bad(8'h01, 1);
    checks++; if (bad != -1) begin failures++; $display("FAIL ign_stream2: first bad byte at %0d expected none", bad); end
    checks++; if (stream_q.size() < FRAME_LEN || stream_q[1] !== 8'h01 || stream_q[FRAME_LEN-1] !== 8'h57) begin
      failures++; $display("FAIL ign_seq_csum: got %0d bytes, seq/csum mismatch expected 01/57", stream_q.size()); end
    $display("test_ignore_start: second frame %0d bytes", stream_q.size());
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int bad;
    stream_q.delete();
    pulse_start();
    wait_bytes(52, 400, to);
    for (int i = 0; i < 10 && !tx_valid; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h50) begin
      failures++; $display("FAIL rst_byte50: got valid=%b data=%h expected 1/50", tx_valid, tx_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++; $display("FAIL rst_async: got valid=%b busy=%b rd_en=%b expected 0/0/0", tx_valid, busy, rd_en); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stream_q.delete();
    pulse_start();
    wait_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL rst_done_timeout: got timeout expected done"); end
    @(posedge clk); #1;
    checks++; if (stream_q.size() < 2 || stream_q[0] !== 8'hA5 || stream_q[1] !== 8'h00) begin
      failures++; $display("FAIL rst_restart_hdr: got %0d bytes, header mismatch expected A5 00", stream_q.size()); end
    bad = first_bad(8'h00, 1);
    checks++; if (bad != -1) begin failures++; $display("FAIL rst_stream: first bad byte at %0d expected none", bad); end
    $display("test_reset_mid_frame: restart %0d bytes", stream_q.size());
  endtask

  task automatic test_back_to_back();
    int n_done;
    bit prev_done;
    int bad;
    do_reset();
    stream_q.delete();
    rise_q.delete();
    n_done = 0;
    prev_done = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (prev_done) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_rise: frame %0d got %b expected 1", n_done, busy); end
      end
      prev_done = done;
      if (done) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: frame %0d got %b expected 0", n_done, busy); end
        n_done++;
        if (n_done == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (n_done != 3) begin failures++; $display("FAIL b2b_frames: got %0d expected 3", n_done); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stop: got busy=%b expected 0", busy); end
    checks++; if (stream_q.size() != 3 * FRAME_LEN) begin failures++; $display("FAIL b2b_len: got %0d expected %0d", stream_q.size(), 3 * FRAME_LEN); end
    bad = first_bad(8'h00, 3);
    checks++; if (bad != -1) begin failures++; $display("FAIL b2b_stream: first bad byte at %0d expected none", bad); end
    checks++; if (stream_q.size() < 3 * FRAME_LEN || stream_q[1] !== 8'h00 || stream_q[FRAME_LEN+1] !== 8'h01 || stream_q[2*FRAME_LEN+1] !== 8'h02) begin
      failures++; $display("FAIL b2b_seq: got %0d bytes, seq bytes mismatch expected 00 01 02", stream_q.size()); end
    $display("test_back_to_back: %0d frames %0d bytes", n_done, stream_q.size());
  endtask

  task automatic test_rd_timing();
    int n_data;
    int n_bad;
    n_data = 0;
    n_bad = 0;
    foreach (rise_q[i]) begin
      if (rise_q[i].busy_prev) begin
        n_data++;
        if (!rise_q[i].rd_en_d2 || rise_q[i].data !== model_sample(int'(rise_q[i].ch_d2), int'(rise_q[i].idx_d2)))
          n_bad++;
      end
    end
    checks++; if (n_data != 3 * NUM_CHANNELS * NUM_SAMPLES) begin
      failures++; $display("FAIL rd_timing_count: got %0d expected %0d", n_data, 3 * NUM_CHANNELS * NUM_SAMPLES); end
    checks++; if (n_bad != 0) begin failures++; $display("FAIL rd_timing_data: got %0d bad bytes expected 0", n_bad); end
    $display("test_rd_timing: %0d data bytes", n_data);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    test_rd_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
